// File: rtl/cordic_pkg.sv
// Shared widths, default pipeline depth and response-entry layout for the
// CORDIC request scheduler and its response buffer.
package cordic_pkg;

    localparam int ANGLE_W     = 25;
    localparam int DATA_W      = 30;
    localparam int QUAD_W      = 3;
    localparam int DEF_LATENCY = 23;
    // Widest tag any requester may use; narrower tags are zero-extended.
    localparam int RSP_TAG_W   = 8;

    typedef struct packed {
        logic                     id;
        logic [RSP_TAG_W-1:0]     tag;
        logic signed [DATA_W-1:0] cos;
        logic signed [DATA_W-1:0] sin;
        logic [QUAD_W-1:0]        quad;
    } rsp_entry_t;

endpackage

// File: rtl/cordic_rsp_fifo.sv
// Synchronous response FIFO. Pointers carry one extra wrap bit so that
// full and empty are distinguishable without a separate counter.
module cordic_rsp_fifo
    import cordic_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  rsp_entry_t wr_data,
    input  logic       rd_en,
    output rsp_entry_t rd_data,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    rsp_entry_t     mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic           full;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Pointer advance; wrap is implicit in the AW+1 bit arithmetic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_en && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (wr_en && !full)
            mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    // Upstream credit gating must never let a write reach a full buffer.
    always_ff @(posedge clk) begin
        if (rst_n)
            assert (!(wr_en && full)) else $error("cordic_rsp_fifo: write while full");
    end

endmodule

// File: rtl/cordic_sched.sv
// Two-requester round-robin scheduler in front of a fixed-latency CORDIC
// pipeline. Metadata rides a shift register alongside the pipeline and the
// aligned results land in an in-order response FIFO. Issue is credit-gated
// on in-flight + buffered count so the FIFO can never overflow.
module cordic_sched
    import cordic_pkg::*;
#(
    parameter int LATENCY    = DEF_LATENCY,
    parameter int FIFO_DEPTH = 32,
    parameter int TAG_W      = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     a_valid,
    output logic                     a_ready,
    input  logic signed [ANGLE_W-1:0] a_angle,
    input  logic [QUAD_W-1:0]        a_quad,
    input  logic [TAG_W-1:0]         a_tag,
    input  logic                     b_valid,
    output logic                     b_ready,
    input  logic signed [ANGLE_W-1:0] b_angle,
    input  logic [QUAD_W-1:0]        b_quad,
    input  logic [TAG_W-1:0]         b_tag,
    output logic signed [ANGLE_W-1:0] pl_angle,
    output logic [QUAD_W-1:0]        pl_quad,
    input  logic signed [DATA_W-1:0] pl_cos,
    input  logic signed [DATA_W-1:0] pl_sin,
    input  logic [QUAD_W-1:0]        pl_quad_o,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic                     rsp_id,
    output logic [TAG_W-1:0]         rsp_tag,
    output logic signed [DATA_W-1:0] rsp_cos,
    output logic signed [DATA_W-1:0] rsp_sin,
    output logic [QUAD_W-1:0]        rsp_quad,
    output logic [5:0]               outstanding
);

    logic                       prio;       // 0: A wins a tie, 1: B wins
    logic                       pop;
    logic                       credit_ok;
    logic                       gnt_a;
    logic                       gnt_b;
    logic                       issue;
    logic [5:0]                 out_after_pop;
    logic [TAG_W-1:0]           issue_tag;

    logic [LATENCY:0]              vld_pipe;
    logic [LATENCY:0]              id_pipe;
    logic [LATENCY:0][TAG_W-1:0]   tag_pipe;

    rsp_entry_t                 wr_entry;
    rsp_entry_t                 rd_entry;
    logic                       fifo_empty;

    // A slot freed by this cycle's pop can be reused in the same cycle.
    assign pop           = rsp_valid && rsp_ready;
    assign out_after_pop = outstanding - {5'd0, pop};
    assign credit_ok     = (out_after_pop < 6'(FIFO_DEPTH));

    assign gnt_a   = a_valid && (!b_valid || !prio);
    assign gnt_b   = b_valid && (!a_valid ||  prio);
    // rst_n gating keeps both readies low for the whole reset window.
    assign a_ready = rst_n && gnt_a && credit_ok;
    assign b_ready = rst_n && gnt_b && credit_ok;
    assign issue   = a_ready || b_ready;
    assign issue_tag = b_ready ? b_tag : a_tag;

    // Pipeline input register: granted request, or a zero bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pl_angle <= '0;
            pl_quad  <= '0;
        end else if (issue) begin
            pl_angle <= b_ready ? b_angle : a_angle;
            pl_quad  <= b_ready ? b_quad  : a_quad;
        end else begin
            pl_angle <= '0;
            pl_quad  <= '0;
        end
    end

    // Round-robin pointer: after a grant, the other requester gets priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            prio <= 1'b0;
        else if (issue)
            prio <= a_ready;
    end

    // Valid bits only need reset; clearing them discards everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            vld_pipe <= '0;
        else
            vld_pipe <= {vld_pipe[LATENCY-1:0], issue};
    end

    // Metadata delay line; stage LATENCY lines up with pl_cos/pl_sin.
    always_ff @(posedge clk) begin
        id_pipe  <= {id_pipe[LATENCY-1:0], b_ready};
        tag_pipe <= {tag_pipe[LATENCY-1:0], issue_tag};
    end

    // In-flight plus buffered count; issue and pop together cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            outstanding <= '0;
        else
            outstanding <= outstanding + {5'd0, issue} - {5'd0, pop};
    end

    always_comb begin
        wr_entry      = '0;
        wr_entry.id   = id_pipe[LATENCY];
        wr_entry.tag  = RSP_TAG_W'(tag_pipe[LATENCY]);
        wr_entry.cos  = pl_cos;
        wr_entry.sin  = pl_sin;
        wr_entry.quad = pl_quad_o;
    end

    cordic_rsp_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (vld_pipe[LATENCY]),
        .wr_data (wr_entry),
        .rd_en   (pop),
        .rd_data (rd_entry),
        .empty   (fifo_empty)
    );

    assign rsp_valid = !fifo_empty;
    assign rsp_id    = rd_entry.id;
    assign rsp_tag   = rd_entry.tag[TAG_W-1:0];
    assign rsp_cos   = rd_entry.cos;
    assign rsp_sin   = rd_entry.sin;
    assign rsp_quad  = rd_entry.quad;

    // Tags are zero-extended on the way in, so the spare bits stay clear.
    always_ff @(posedge clk) begin
        if (rst_n && rsp_valid)
            assert ((rd_entry.tag >> TAG_W) == '0) else $error("cordic_sched: tag high bits set");
    end

endmodule

// File: tb/tb_cordic_sched.sv
// Bench for cordic_sched: a delay-line stand-in for the CORDIC pipeline and
// a queue-based model of accepted-but-unanswered requests.
module tb_cordic_sched;

    localparam int LAT   = 23;
    localparam int DEPTH = 32;
    localparam int TW    = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          a_valid, a_ready, b_valid, b_ready;
    logic [24:0]   a_angle, b_angle;
    logic [2:0]    a_quad, b_quad;
    logic [TW-1:0] a_tag, b_tag;
    logic [24:0]   pl_angle;
    logic [2:0]    pl_quad, pl_quad_o;
    logic [29:0]   pl_cos, pl_sin;
    logic          rsp_valid, rsp_ready, rsp_id;
    logic [TW-1:0] rsp_tag;
    logic [29:0]   rsp_cos, rsp_sin;
    logic [2:0]    rsp_quad;
    logic [5:0]    outstanding;

    cordic_sched #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH), .TAG_W(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_angle(a_angle), .a_quad(a_quad), .a_tag(a_tag),
        .b_valid(b_valid), .b_ready(b_ready), .b_angle(b_angle), .b_quad(b_quad), .b_tag(b_tag),
        .pl_angle(pl_angle), .pl_quad(pl_quad),
        .pl_cos(pl_cos), .pl_sin(pl_sin), .pl_quad_o(pl_quad_o),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_tag(rsp_tag),
        .rsp_cos(rsp_cos), .rsp_sin(rsp_sin), .rsp_quad(rsp_quad),
        .outstanding(outstanding)
    );

    function automatic logic [29:0] cos_f(input logic [24:0] a, input logic [2:0] q);
        return {q, 2'b01, a};
    endfunction
    function automatic logic [29:0] sin_f(input logic [24:0] a, input logic [2:0] q);
        return {a, q, 2'b10};
    endfunction

    // Pipeline stand-in: LAT cycles from the input register to the outputs.
    logic [24:0] ang_d [LAT];
    logic [2:0]  quad_d [LAT];
    always @(posedge clk) begin
        ang_d[0]  <= pl_angle;
        quad_d[0] <= pl_quad;
        for (int i = 1; i < LAT; i++) begin
            ang_d[i]  <= ang_d[i-1];
            quad_d[i] <= quad_d[i-1];
        end
    end
    assign pl_cos    = cos_f(ang_d[LAT-1], quad_d[LAT-1]);
    assign pl_sin    = sin_f(ang_d[LAT-1], quad_d[LAT-1]);
    assign pl_quad_o = quad_d[LAT-1];

    typedef struct {
        bit            id;
        logic [TW-1:0] tag;
        logic [24:0]   angle;
        logic [2:0]    quad;
        int            acc;
    } req_t;

    req_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_n = 0;
    bit   prio_m = 1'b0;
    int   first_rsp = -1;
    int   na = 0, nb = 0, nrsp = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock: check DUT against the model mid-cycle, update the model,
    // then advance to just after the next rising edge.
    task automatic cyc();
        bit   exp_rv, pop, credit, exp_a, exp_b;
        req_t r;
        #4;
        if (rsp_valid) nrsp++;
        if (rsp_valid && rsp_ready && first_rsp < 0) first_rsp = cyc_n;
        if (a_valid && a_ready) na++;
        if (b_valid && b_ready) nb++;
        if (!rst_n) begin
            chk("rst_a_ready", a_ready, 0);
            chk("rst_b_ready", b_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_outstanding", outstanding, 0);
            chk("rst_pl_angle", pl_angle, 0);
            chk("rst_pl_quad", pl_quad, 0);
            q.delete();
            prio_m = 1'b0;
        end else begin
            exp_rv = (q.size() > 0) && (cyc_n >= q[0].acc + LAT + 2);
            chk("rsp_valid", rsp_valid, exp_rv);
            if (exp_rv) begin
                chk("rsp_id", rsp_id, q[0].id);
                chk("rsp_tag", rsp_tag, q[0].tag);
                chk("rsp_cos", rsp_cos, cos_f(q[0].angle, q[0].quad));
                chk("rsp_sin", rsp_sin, sin_f(q[0].angle, q[0].quad));
                chk("rsp_quad", rsp_quad, q[0].quad);
            end
            chk("outstanding", outstanding, q.size());
            pop    = exp_rv && rsp_ready;
            credit = (q.size() - int'(pop)) < DEPTH;
            exp_a  = a_valid && (!b_valid || !prio_m) && credit;
            exp_b  = b_valid && (!a_valid ||  prio_m) && credit;
            chk("a_ready", a_ready, exp_a);
            chk("b_ready", b_ready, exp_b);
            if (pop) void'(q.pop_front());
            if (exp_a) begin
                r = '{id: 1'b0, tag: a_tag, angle: a_angle, quad: a_quad, acc: cyc_n};
                q.push_back(r);
                prio_m = 1'b1;
            end else if (exp_b) begin
                r = '{id: 1'b1, tag: b_tag, angle: b_angle, quad: b_quad, acc: cyc_n};
                q.push_back(r);
                prio_m = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic rand_fields();
        a_angle = 25'($urandom);
        a_quad  = 3'($urandom);
        a_tag   = TW'($urandom);
        b_angle = 25'($urandom);
        b_quad  = 3'($urandom);
        b_tag   = TW'($urandom);
    endtask

    initial begin
        int acc;
        a_valid = 1'b1; b_valid = 1'b1; rsp_ready = 1'b1;
        rand_fields();

        // Reset: readies held low even with both requesters valid.
        repeat (3) cyc();
        a_valid = 1'b0; b_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) cyc();

        // Single A request: exact accept-to-response latency.
        a_valid = 1'b1; a_angle = '0; a_quad = '0; a_tag = 4'd5;
        acc = cyc_n; first_rsp = -1;
        cyc();
        a_valid = 1'b0;
        repeat (30) cyc();
        chk("single_latency", 64'(first_rsp - acc), 64'(LAT + 2));

        // Both valid every cycle: grants alternate.
        na = 0; nb = 0;
        a_valid = 1'b1; b_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rand_fields();
            cyc();
        end
        chk("alt_grants_a", na, 20);
        chk("alt_grants_b", nb, 20);
        a_valid = 1'b0; b_valid = 1'b0;
        repeat (30) cyc();

        // Back-pressure: A streams with rsp_ready low until credits run out.
        rsp_ready = 1'b0; a_valid = 1'b1; na = 0;
        for (int i = 0; i < 60; i++) begin
            rand_fields();
            cyc();
        end
        chk("stall_accepts", na, DEPTH);
        chk("stall_outstanding", outstanding, DEPTH);
        #1;
        chk("stall_a_ready", a_ready, 0);
        rsp_ready = 1'b1;
        cyc();
        chk("issue_pop_outstanding", outstanding, DEPTH);
        for (int i = 0; i < 40; i++) begin
            rand_fields();
            cyc();
        end
        a_valid = 1'b0;
        repeat (40) cyc();
        chk("drain1_outstanding", outstanding, 0);

        // Reset with ten requests in flight.
        a_valid = 1'b1; b_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rand_fields();
            cyc();
        end
        a_valid = 1'b0; b_valid = 1'b0;
        rst_n = 1'b0;
        repeat (3) cyc();
        rst_n = 1'b1;
        nrsp = 0;
        repeat (30) cyc();
        chk("post_rst_no_rsp", nrsp, 0);
        chk("post_rst_outstanding", outstanding, 0);
        a_valid = 1'b1; b_valid = 1'b1;
        rand_fields();
        #1;
        chk("post_rst_grant_a", a_ready, 1);
        chk("post_rst_grant_b", b_ready, 0);
        cyc();

        // Randomized traffic with random back-pressure.
        for (int i = 0; i < 300; i++) begin
            a_valid   = ($urandom_range(0, 9) < 6);
            b_valid   = ($urandom_range(0, 9) < 6);
            rsp_ready = ($urandom_range(0, 9) < 7);
            rand_fields();
            cyc();
        end
        a_valid = 1'b0; b_valid = 1'b0; rsp_ready = 1'b1;
        repeat (70) cyc();
        chk("final_outstanding", outstanding, 0);
        chk("final_rsp_valid", rsp_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
